// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment scanner with per-frame shadow capture.
// Optional leading-zero blanking when SEG7_LEADING_ZERO_BLANK_EN is defined.
module seg7_scan #(
  parameter int SCAN_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blank_in,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic [7:0]  an,
  output logic        frame
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(SCAN_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [31:0]   sh_data;
  logic [31:0]   data_nx;
  logic [7:0]    sh_point;
  logic [7:0]    point_nx;
  logic [7:0]    sh_blank;
  logic [7:0]    blank_nx;
  logic [7:0]    lz_nx;
  logic          wrap;
  logic          load;
  logic          guard;

  always_comb begin
    wrap     = (cnt == LAST);
    load     = en && wrap && (idx == 3'd7);
    cnt_nx   = cnt;
    idx_nx   = idx;
    if (en) begin
      cnt_nx = wrap ? '0 : cnt + CW'(1);
      if (wrap) idx_nx = idx + 3'd1;
    end
    data_nx  = load ? data : sh_data;
    point_nx = load ? point_in : sh_point;
    blank_nx = load ? blank_in : sh_blank;
  end

  // Dead time at the start of each slot keeps the previous digit from ghosting.
  if (GUARD_CYCLES > 0) begin : g_guard
    assign guard = (cnt_nx < CW'(GUARD_CYCLES));
  end else begin : g_noguard
    assign guard = 1'b0;
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [7:0] lz;
  logic       zrun;

  always_comb begin
    lz_nx = lz;
    zrun  = 1'b1;
    if (load) begin
      lz_nx = '0;
      for (int i = 7; i >= 1; i--) begin
        zrun     = zrun & (data[4*i +: 4] == 4'h0);
        lz_nx[i] = zrun;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lz <= '0;
    else        lz <= lz_nx;
  end
`else
  assign lz_nx = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      sh_data  <= '0;
      sh_point <= '0;
      sh_blank <= '0;
      hex      <= '0;
      point    <= 1'b0;
      le       <= 1'b1;
      an       <= 8'hFF;
      frame    <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      sh_data  <= data_nx;
      sh_point <= point_nx;
      sh_blank <= blank_nx;
      frame    <= load;
      if (en) begin
        an    <= guard ? 8'hFF : ~(8'b1 << idx_nx);
        hex   <= data_nx[{idx_nx, 2'b00} +: 4];
        point <= point_nx[idx_nx];
        le    <= blank_nx[idx_nx] | lz_nx[idx_nx] | guard;
      end else begin
        an    <= 8'hFF;
        le    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: SCAN_CYCLES=8, guard 2 (u0) and guard 0 (u1).
// Leading-zero expectations follow SEG7_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  point_in = '0;
  logic [7:0]  blank_in = '0;

  logic [3:0] hex0, hex1;
  logic       point0, point1;
  logic       le0, le1;
  logic [7:0] an0, an1;
  logic       frame0, frame1;

  int total = 0;
  int bad = 0;
  int pos = 0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_point = '0;
  logic [7:0]  m_blank = '0;

  logic [3:0] old_tbl [8];
  logic [3:0] new_tbl [8];

  seg7_scan #(.SCAN_CYCLES(8), .GUARD_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .point_in(point_in), .blank_in(blank_in),
    .hex(hex0), .point(point0), .le(le0), .an(an0), .frame(frame0)
  );

  seg7_scan #(.SCAN_CYCLES(8), .GUARD_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .point_in(point_in), .blank_in(blank_in),
    .hex(hex1), .point(point1), .le(le1), .an(an1), .frame(frame1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // pos = idx*8 + cnt of the enabled scan position after the last edge.
  task automatic tick();
    @(posedge clk);
    if (en && rst_n) begin
      if (pos == 63) begin
        m_data  = data;
        m_point = point_in;
        m_blank = blank_in;
      end
      pos = (pos + 1) % 64;
    end
    #1;
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i < 70 && pos != p; i++) tick();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    data = 32'h12345678;
    en = 1'b1;
    rst_n = 1'b1;
    pos = 0;
    repeat (70) tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (an0 !== 8'hFF) begin bad++; $display("FAIL rst_an got=%h want=ff", an0); end
    total++;
    if (le0 !== 1'b1) begin bad++; $display("FAIL rst_le got=%b want=1", le0); end
    total++;
    if (frame0 !== 1'b0) begin bad++; $display("FAIL rst_frame got=%b want=0", frame0); end
    total++;
    if (hex0 !== 4'h0) begin bad++; $display("FAIL rst_hex got=%h want=0", hex0); end
    total++;
    if (point0 !== 1'b0) begin bad++; $display("FAIL rst_point got=%b want=0", point0); end
    @(posedge clk); #1;
    total++;
    if (an0 !== 8'hFF || le0 !== 1'b1 || an1 !== 8'hFF) begin
      bad++; $display("FAIL rst_hold an0=%h le0=%b an1=%h want ff 1 ff", an0, le0, an1);
    end
    rst_n = 1'b1;
    pos = 0;
    m_data = '0;
    m_point = '0;
    m_blank = '0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      total++;
      if (frame0 !== (k == 64)) begin
        bad++; $display("FAIL first_frame k=%0d got=%b want=%b", k, frame0, (k == 64));
      end
      if (k == 1) begin
        total++;
        if (an0 !== 8'hFF) begin bad++; $display("FAIL first_an k=1 got=%h want=ff", an0); end
      end
      if (k == 2) begin
        total++;
        if (an0 !== 8'hFE) begin bad++; $display("FAIL first_an k=2 got=%h want=fe", an0); end
      end
      if (k == 10) begin
        total++;
        if (hex0 !== 4'h0 || an0 !== 8'hFD) begin
          bad++; $display("FAIL zero_shadow hex=%h an=%h want 0 fd", hex0, an0);
        end
      end
    end
  endtask

  task automatic test_scan();
    int d, c;
    old_tbl = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    for (int s = 0; s < 64; s++) begin
      if (s != 0) tick();
      d = s / 8;
      c = s % 8;
      total++;
      if (an0 !== ((c < 2) ? 8'hFF : ~(8'b1 << d))) begin
        bad++; $display("FAIL scan_an d=%0d c=%0d got=%h", d, c, an0);
      end
      total++;
      if (hex0 !== old_tbl[d]) begin
        bad++; $display("FAIL scan_hex d=%0d got=%h want=%h", d, hex0, old_tbl[d]);
      end
      total++;
      if (le0 !== (c < 2)) begin
        bad++; $display("FAIL scan_le d=%0d c=%0d got=%b want=%b", d, c, le0, (c < 2));
      end
    end
  endtask

  task automatic test_coherence();
    int d, c;
    new_tbl = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
    goto_pos(26);
    data = 32'hDEADBEEF;
    while (pos != 63) begin
      tick();
      d = pos / 8;
      c = pos % 8;
      if (c == 4) begin
        total++;
        if (hex0 !== old_tbl[d]) begin
          bad++; $display("FAIL coh_old d=%0d got=%h want=%h", d, hex0, old_tbl[d]);
        end
      end
    end
    tick();
    total++;
    if (frame0 !== 1'b1) begin bad++; $display("FAIL coh_frame got=%b want=1", frame0); end
    for (int s = 0; s < 64; s++) begin
      if (s != 0) tick();
      d = s / 8;
      total++;
      if (hex0 !== new_tbl[d]) begin
        bad++; $display("FAIL coh_new d=%0d got=%h want=%h", d, hex0, new_tbl[d]);
      end
    end
  endtask

  task automatic test_point_blank();
    int d, c;
    goto_pos(5);
    point_in = 8'h05;
    blank_in = 8'h80;
    goto_pos(63);
    tick();
    for (int s = 0; s < 64; s++) begin
      if (s != 0) tick();
      d = s / 8;
      c = s % 8;
      total++;
      if (point0 !== (d == 0 || d == 2)) begin
        bad++; $display("FAIL pb_point d=%0d got=%b", d, point0);
      end
      total++;
      if (le0 !== (d == 7 || c < 2)) begin
        bad++; $display("FAIL pb_le d=%0d c=%0d got=%b", d, c, le0);
      end
      total++;
      if (frame0 !== (s == 0)) begin
        bad++; $display("FAIL pb_frame s=%0d got=%b", s, frame0);
      end
    end
  endtask

  task automatic test_freeze();
    goto_pos(43);
    en = 1'b0;
    repeat (20) begin
      tick();
      total++;
      if (an0 !== 8'hFF || le0 !== 1'b1 || frame0 !== 1'b0 || an1 !== 8'hFF) begin
        bad++; $display("FAIL frz_out an0=%h le0=%b fr=%b an1=%h", an0, le0, frame0, an1);
      end
      total++;
      if (hex0 !== 4'hA) begin bad++; $display("FAIL frz_hex got=%h want=a", hex0); end
    end
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (k <= 4) begin
        if (an0 !== 8'hDF || hex0 !== 4'hA || le0 !== 1'b0) begin
          bad++; $display("FAIL frz_resume k=%0d an=%h hex=%h le=%b", k, an0, hex0, le0);
        end
      end else begin
        if (an0 !== 8'hFF || hex0 !== 4'hE || le0 !== 1'b1) begin
          bad++; $display("FAIL frz_next an=%h hex=%h le=%b want ff e 1", an0, hex0, le0);
        end
      end
    end
  endtask

  task automatic test_guard_zero();
    int d;
    repeat (256) begin
      tick();
      d = pos / 8;
      total++;
      if (an1 !== ~(8'b1 << d) || $countones(~an1) != 1) begin
        bad++; $display("FAIL g0_an d=%0d got=%h", d, an1);
      end
      total++;
      if (le1 !== m_blank[d]) begin
        bad++; $display("FAIL g0_le d=%0d got=%b want=%b", d, le1, m_blank[d]);
      end
      total++;
      if (hex1 !== m_data[4*d +: 4]) begin
        bad++; $display("FAIL g0_hex d=%0d got=%h want=%h", d, hex1, m_data[4*d +: 4]);
      end
    end
  endtask

  task automatic test_leading_zero();
    int d, c;
    logic [7:0] lzm;
    logic [3:0] low_tbl [3];
    low_tbl = '{4'h0, 4'h0, 4'hA};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lzm = 8'hF8;
`else
    lzm = 8'h00;
`endif
    point_in = '0;
    blank_in = '0;
    data = 32'h00000A00;
    goto_pos(63);
    tick();
    for (int s = 0; s < 64; s++) begin
      if (s != 0) tick();
      d = s / 8;
      c = s % 8;
      total++;
      if (le0 !== (lzm[d] | (c < 2))) begin
        bad++; $display("FAIL lz_le d=%0d c=%0d got=%b", d, c, le0);
      end
      total++;
      if (le1 !== lzm[d]) begin
        bad++; $display("FAIL lz_le_g0 d=%0d got=%b want=%b", d, le1, lzm[d]);
      end
      if (d <= 2) begin
        total++;
        if (hex0 !== low_tbl[d]) begin
          bad++; $display("FAIL lz_hex d=%0d got=%h want=%h", d, hex0, low_tbl[d]);
        end
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lzm = 8'hFE;
`else
    lzm = 8'h00;
`endif
    data = 32'h0;
    goto_pos(63);
    tick();
    for (int s = 0; s < 64; s++) begin
      if (s != 0) tick();
      d = s / 8;
      c = s % 8;
      total++;
      if (le0 !== (lzm[d] | (c < 2))) begin
        bad++; $display("FAIL lz0_le d=%0d c=%0d got=%b", d, c, le0);
      end
      total++;
      if (hex0 !== 4'h0) begin bad++; $display("FAIL lz0_hex d=%0d got=%h want=0", d, hex0); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherence();
    test_point_blank();
    test_freeze();
    test_guard_zero();
    test_leading_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
